mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the pipelined RV32I core, directly downstream of the execute stage. It takes the execute result (ALU output, rs2 data, func3, destination register, op class), drives a single-outstanding data-memory request/acknowledge handshake, aligns and extends load data, and produces the registered write-back bundle. It stalls the upstream pipeline while a memory access is outstanding and flags misaligned or illegal accesses.

## Interface
Parameters:
- `XLEN`, 32: data/address width.
- `RegAddrWidth`, 5: register index width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `inValid`  in  1  execute bundle present this cycle.
- `inOp`  in  2  op class: NONE=0, REGWRITE=1, LOAD=2, STORE=3.
- `inFunc3`  in  3  RV32I load/store width code.
- `inAddr`  in  XLEN  ALU result: effective address for LOAD/STORE, write-back value for REGWRITE.
- `inStoreData`  in  XLEN  rs2 value.
- `inRd`  in  RegAddrWidth  destination register.
- `stall`  out  1  upstream must hold its bundle.
- `memReq`  out  1  memory request valid.
- `memWe`  out  1  1 = store.
- `memAddr`  out  XLEN  word-aligned address (low two bits zero).
- `memWdata`  out  XLEN  lane-replicated store data.
- `memStrb`  out  4  byte-lane enables.
- `memAck`  in  1  request completed; `memRdata` valid in the same cycle.
- `memRdata`  in  XLEN  read word.
- `wbValid`  out  1  write-back bundle valid.
- `wbRd`  out  RegAddrWidth  write-back register.
- `wbData`  out  XLEN  write-back value.
- `err`  out  1  one-cycle pulse for a misaligned or illegal access.

## Operation
- States: IDLE, WAIT.
- IDLE, bundle accepted when `inValid` is high and `stall` is low:
  - NONE: no effect.
  - REGWRITE: `wbValid`=1, `wbData`=`inAddr`, `wbRd`=`inRd` on the next cycle.
  - LOAD/STORE legal and aligned: latch the request fields and enter WAIT.
  - LOAD/STORE misaligned or illegal: `err` pulses next cycle; no request, no write-back, stay IDLE.
- Legal loads: func3 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. Legal stores: 0 sb, 1 sh, 2 sw. All other func3 values are illegal.
- Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
- Store lanes:
  - sb: `memStrb`=0001<<addr[1:0], byte replicated four times.
  - sh: `memStrb`=0011<<addr[1:0], halfword replicated twice.
  - sw: `memStrb`=1111.
  - Loads: `memStrb`=0000.
- WAIT: `memReq` held high with stable fields until `memAck` is sampled high. Then return to IDLE.
  - Load: write-back of the extracted lane, sign- or zero-extended per func3, appears next cycle.
  - Store: no write-back.
- `stall` = (state == WAIT).
- `wbRd`=0 is still reported as valid; the register file discards it.
- `memAck` while IDLE is ignored.

## Timing
- Reset values:
  - `memReq`, `memWe`, `wbValid`, `err`, `stall` = 0.
  - `memAddr`, `memWdata`, `memStrb`, `wbRd`, `wbData` = 0.
  - State = IDLE.
- REGWRITE latency: 1 cycle.
- Memory op: `memReq` rises the cycle after acceptance. Load write-back appears the cycle after the `memAck` cycle. Minimum load latency is 2 cycles with zero-wait-state memory.
- `wbValid` and `err` are single-cycle pulses, registered.
- `stall` is high from the first WAIT cycle through the `memAck` cycle inclusive. A bundle presented during the ack cycle is accepted on the following cycle.
- Reset during WAIT:
  - Drop `memReq` on the next edge.
  - Discard the pending access; no write-back.
  - A late `memAck` is ignored.

## Structure
- Shared package `mem_pkg`:
  - op-class constants NONE, REGWRITE, LOAD, STORE;
  - func3 load/store constants;
  - state encoding IDLE, WAIT.
- Sub-module `load_align`: combinational; inputs word, addr[1:0], func3; output extended XLEN value.
- FSM, request registers and write-back registers live in `mem_access`.

## Test plan
- REGWRITE, inAddr=0x1234_5678, rd=5 → next cycle wbValid=1, wbRd=5, wbData=0x1234_5678, no memReq.
- LOAD lb, addr=0x103, memRdata=0x80FF_0000, ack after 2 wait cycles → memAddr=0x100, stall high 3 cycles, wbData=0xFFFF_FF80; repeat with lbu → 0x0000_0080.
- STORE sh, addr=0x202, data=0x0000_ABCD → memAddr=0x200, memStrb=1100, memWdata=0xABCD_ABCD, memWe=1, no wbValid.
- LOAD lw, addr=0x101 → err pulse next cycle; memReq stays 0; wbValid stays 0; stall stays 0.
- Reset asserted in the second WAIT cycle of a load, then memAck=1 → memReq=0 after the edge, no wbValid, state IDLE.
- Back-to-back: sw then REGWRITE presented during WAIT → REGWRITE held and accepted the cycle after ack; its write-back appears one cycle later.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and helpers for the memory-access stage
// Contents: op-class codes, RV32I load/store func3 codes, FSM state encoding,
//           legality/alignment check and store byte-lane enables.
package mem_pkg;

    // Op class carried from the execute stage
    localparam logic [1:0] NONE     = 2'd0;
    localparam logic [1:0] REGWRITE = 2'd1;
    localparam logic [1:0] LOAD     = 2'd2;
    localparam logic [1:0] STORE    = 2'd3;

    // RV32I load/store width codes
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // FSM state encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    // True when the access is a legal func3 for its op class and naturally aligned.
    function automatic logic access_ok(input logic [1:0] op, input logic [2:0] f3,
                                       input logic [1:0] lane);
        logic legal;
        logic aligned;
        if (op == LOAD) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        // Bits [1:0] of func3 give the access size for every legal code
        case (f3[1:0])
            2'd1:    aligned = ~lane[0];
            2'd2:    aligned = (lane == 2'd0);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

    // Byte-lane enables for a store; only called for legal, aligned stores.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] strb;
        case (f3[1:0])
            2'd0:    strb = 4'b0001 << lane;
            2'd1:    strb = 4'b0011 << lane;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and extends the addressed lane of a load word
// Ports: word   - full read word from memory
//        lane   - byte offset addr[1:0] of the load
//        func3  - load width/sign code
//        result - sign- or zero-extended load value
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    // Bring the addressed byte/halfword down to bit 0
    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        result = '0;
        case (func3)
            F3_B:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    result = word;
            F3_BU:   result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory-access pipeline stage with single-outstanding request
// Ports: clk/reset                  - clock, synchronous active-high reset
//        inValid..inRd              - execute-stage bundle
//        stall                      - upstream hold while a request is outstanding
//        memReq..memStrb, memAck/memRdata - data-memory request/acknowledge
//        wbValid/wbRd/wbData        - registered write-back bundle
//        err                        - pulse for misaligned or illegal access
module mem_access
    import mem_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inValid,
    input  logic [1:0]              inOp,
    input  logic [2:0]              inFunc3,
    input  logic [XLEN-1:0]         inAddr,
    input  logic [XLEN-1:0]         inStoreData,
    input  logic [RegAddrWidth-1:0] inRd,
    output logic                    stall,
    output logic                    memReq,
    output logic                    memWe,
    output logic [XLEN-1:0]         memAddr,
    output logic [XLEN-1:0]         memWdata,
    output logic [3:0]              memStrb,
    input  logic                    memAck,
    input  logic [XLEN-1:0]         memRdata,
    output logic                    wbValid,
    output logic [RegAddrWidth-1:0] wbRd,
    output logic [XLEN-1:0]         wbData,
    output logic                    err
);

    logic [0:0]              state_q,     state_d;
    logic                    mem_we_q,    mem_we_d;
    logic [XLEN-1:0]         mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_strb_q,  mem_strb_d;
    logic [2:0]              req_f3_q,    req_f3_d;
    logic [1:0]              req_lane_q,  req_lane_d;
    logic [RegAddrWidth-1:0] req_rd_q,    req_rd_d;
    logic                    wb_valid_q,  wb_valid_d;
    logic [RegAddrWidth-1:0] wb_rd_q,     wb_rd_d;
    logic [XLEN-1:0]         wb_data_q,   wb_data_d;
    logic                    err_q,       err_d;
    logic [XLEN-1:0]         load_data;

    load_align #(.XLEN(XLEN)) u_load_align (
        .word   (memRdata),
        .lane   (req_lane_q),
        .func3  (req_f3_q),
        .result (load_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_strb_d  = mem_strb_q;
        req_f3_d    = req_f3_q;
        req_lane_d  = req_lane_q;
        req_rd_d    = req_rd_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;

        if (state_q == IDLE) begin
            // memAck in IDLE has no pending access to complete and is ignored
            if (inValid) begin
                case (inOp)
                    REGWRITE: begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = inRd;
                        wb_data_d  = inAddr;
                    end
                    LOAD, STORE: begin
                        if (access_ok(inOp, inFunc3, inAddr[1:0])) begin
                            state_d    = WAIT;
                            mem_we_d   = (inOp == STORE);
                            mem_addr_d = {inAddr[XLEN-1:2], 2'b00};
                            req_f3_d   = inFunc3;
                            req_lane_d = inAddr[1:0];
                            req_rd_d   = inRd;
                            if (inOp == STORE) begin
                                mem_strb_d = store_strb(inFunc3, inAddr[1:0]);
                                case (inFunc3[1:0])
                                    2'd0:    mem_wdata_d = {(XLEN/8){inStoreData[7:0]}};
                                    2'd1:    mem_wdata_d = {(XLEN/16){inStoreData[15:0]}};
                                    default: mem_wdata_d = inStoreData;
                                endcase
                            end else begin
                                mem_strb_d  = 4'b0000;
                                mem_wdata_d = '0;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            if (memAck) begin
                state_d = IDLE;
                if (!mem_we_q) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = req_rd_q;
                    wb_data_d  = load_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_strb_q  <= 4'b0000;
            req_f3_q    <= 3'd0;
            req_lane_q  <= 2'd0;
            req_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_strb_q  <= mem_strb_d;
            req_f3_q    <= req_f3_d;
            req_lane_q  <= req_lane_d;
            req_rd_q    <= req_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

    // The request is outstanding for exactly the WAIT state, so reset drops it on the next edge
    assign memReq   = (state_q == WAIT);
    assign stall    = (state_q == WAIT);
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;
    assign memStrb  = mem_strb_q;
    assign wbValid  = wb_valid_q;
    assign wbRd     = wb_rd_q;
    assign wbData   = wb_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard testbench for mem_access
module tb_mem_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [1:0]  inOp;
    logic [2:0]  inFunc3;
    logic [31:0] inAddr;
    logic [31:0] inStoreData;
    logic [4:0]  inRd;
    logic        stall, memReq, memWe, memAck, wbValid, err;
    logic [31:0] memAddr, memWdata, memRdata, wbData;
    logic [3:0]  memStrb;
    logic [4:0]  wbRd;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } mreq_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    mreq_t exp_req[$];
    wb_t   exp_wb[$];
    int    exp_err = 0;
    int    checks  = 0;
    int    errors  = 0;
    bit    mon_en  = 1'b0;
    bit    req_seen = 1'b0;
    mreq_t cur_req;

    always #5 clk = ~clk;

    mem_access #(.XLEN(32), .RegAddrWidth(5)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inOp(inOp), .inFunc3(inFunc3),
        .inAddr(inAddr), .inStoreData(inStoreData), .inRd(inRd), .stall(stall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memStrb(memStrb), .memAck(memAck), .memRdata(memRdata), .wbValid(wbValid),
        .wbRd(wbRd), .wbData(wbData), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one
    always @(negedge clk) begin
        if (mon_en) begin
            if (wbValid) begin
                if (exp_wb.size() == 0) begin
                    check("wb_unexpected", {31'd0, wbValid}, 32'd0);
                end else begin
                    wb_t w;
                    w = exp_wb.pop_front();
                    check("wb_rd", {27'd0, wbRd}, {27'd0, w.rd});
                    check("wb_data", wbData, w.data);
                end
            end
            if (err) begin
                if (exp_err == 0) check("err_unexpected", {31'd0, err}, 32'd0);
                else begin
                    checks++;
                    exp_err--;
                end
            end
            if (memReq) begin
                if (!req_seen) begin
                    if (exp_req.size() == 0) begin
                        check("req_unexpected", {31'd0, memReq}, 32'd0);
                    end else begin
                        cur_req = exp_req.pop_front();
                        check("req_addr", memAddr, cur_req.addr);
                        check("req_we", {31'd0, memWe}, {31'd0, cur_req.we});
                        check("req_strb", {28'd0, memStrb}, {28'd0, cur_req.strb});
                        if (cur_req.we) check("req_wdata", memWdata, cur_req.wdata);
                    end
                    req_seen = 1'b1;
                end else begin
                    check("req_addr_stable", memAddr, cur_req.addr);
                    check("req_strb_stable", {28'd0, memStrb}, {28'd0, cur_req.strb});
                end
            end else begin
                req_seen = 1'b0;
            end
        end
    end

    // Present a bundle for one accepting edge; returns at #1 after that edge
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd);
        inValid = 1'b1; inOp = op; inFunc3 = f3; inAddr = addr; inStoreData = sdata; inRd = rd;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    // Memory responder: acks after 'waits' non-ack WAIT cycles; n = stall-high cycles seen
    task automatic mem_cycle(input int waits, input logic [31:0] rdata, output int n);
        n = 0;
        while (stall && n < 50) begin
            memAck   = (n == waits);
            memRdata = rdata;
            @(posedge clk); #1;
            n++;
        end
        memAck = 1'b0;
    endtask

    task automatic load_test(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [4:0] rd, input int waits, input logic [31:0] expd);
        int n;
        exp_req.push_back('{addr: {addr[31:2], 2'b00}, we: 1'b0, wdata: 32'd0, strb: 4'b0000});
        exp_wb.push_back('{rd: rd, data: expd});
        issue(LOAD, f3, addr, 32'h0, rd);
        check("load_stall_first", {31'd0, stall}, 32'd1);
        mem_cycle(waits, rdata, n);
        check("load_stall_cycles", n, waits + 1);
        check("load_wb_timing", {31'd0, wbValid}, 32'd1);
        check("load_stall_released", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic store_test(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [3:0] strb, input logic [31:0] wdata, input int waits);
        int n;
        exp_req.push_back('{addr: {addr[31:2], 2'b00}, we: 1'b1, wdata: wdata, strb: strb});
        issue(STORE, f3, addr, sdata, 5'd1);
        mem_cycle(waits, 32'hFFFF_FFFF, n);
        check("store_stall_cycles", n, waits + 1);
        check("store_no_wb", {31'd0, wbValid}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic err_test(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr);
        exp_err++;
        issue(op, f3, addr, 32'h1234_5678, 5'd4);
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_no_req", {31'd0, memReq}, 32'd0);
        check("err_no_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check("err_single", {31'd0, err}, 32'd0);
        check("err_no_req2", {31'd0, memReq}, 32'd0);
        check("err_no_wb", {31'd0, wbValid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; inValid = 1'b0; inOp = NONE; inFunc3 = 3'd0; inAddr = '0;
        inStoreData = '0; inRd = '0; memAck = 1'b0; memRdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_memReq", {31'd0, memReq}, 32'd0);
        check("rst_memWe", {31'd0, memWe}, 32'd0);
        check("rst_wbValid", {31'd0, wbValid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_memWdata", memWdata, 32'd0);
        check("rst_memStrb", {28'd0, memStrb}, 32'd0);
        check("rst_wbRd", {27'd0, wbRd}, 32'd0);
        check("rst_wbData", wbData, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // REGWRITE, 1-cycle latency, single pulse
        exp_wb.push_back('{rd: 5'd5, data: 32'h1234_5678});
        issue(REGWRITE, 3'd0, 32'h1234_5678, 32'h0, 5'd5);
        check("rw_wbValid", {31'd0, wbValid}, 32'd1);
        check("rw_no_req", {31'd0, memReq}, 32'd0);
        @(posedge clk); #1;
        check("rw_pulse", {31'd0, wbValid}, 32'd0);

        // NONE op: nothing happens
        issue(NONE, 3'd0, 32'h0000_0100, 32'h0, 5'd6);
        check("none_no_req", {31'd0, memReq}, 32'd0);
        check("none_no_wb", {31'd0, wbValid}, 32'd0);

        // Loads
        load_test(F3_B,  32'h0000_0103, 32'h80FF_0000, 5'd3, 2, 32'hFFFF_FF80);
        load_test(F3_BU, 32'h0000_0103, 32'h80FF_0000, 5'd3, 2, 32'h0000_0080);
        load_test(F3_H,  32'h0000_0002, 32'h8001_1234, 5'd8, 1, 32'hFFFF_8001);
        load_test(F3_HU, 32'h0000_0000, 32'h8001_F00D, 5'd9, 0, 32'h0000_F00D);
        load_test(F3_W,  32'h0000_0004, 32'hCAFE_BABE, 5'd0, 0, 32'hCAFE_BABE);

        // Stores
        store_test(F3_H, 32'h0000_0202, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 1);
        store_test(F3_B, 32'h0000_0301, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A, 0);
        store_test(F3_W, 32'h0000_040C, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 2);

        // Misaligned / illegal
        err_test(LOAD,  F3_W, 32'h0000_0101);
        err_test(LOAD,  3'd3, 32'h0000_0000);
        err_test(STORE, F3_BU, 32'h0000_0000);
        err_test(STORE, F3_H, 32'h0000_0203);
        err_test(LOAD,  F3_H, 32'h0000_0001);

        // memAck while IDLE is ignored
        memAck = 1'b1; memRdata = 32'h5555_5555;
        repeat (2) begin @(posedge clk); #1; end
        memAck = 1'b0;
        check("idle_ack_no_wb", {31'd0, wbValid}, 32'd0);
        check("idle_ack_no_req", {31'd0, memReq}, 32'd0);

        // Reset in the second WAIT cycle of a load, then a late ack
        exp_req.push_back('{addr: 32'h0000_0500, we: 1'b0, wdata: 32'd0, strb: 4'b0000});
        issue(LOAD, F3_W, 32'h0000_0500, 32'h0, 5'd7);
        @(posedge clk); #1;
        check("rstw_req_before", {31'd0, memReq}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstw_req_dropped", {31'd0, memReq}, 32'd0);
        check("rstw_stall_dropped", {31'd0, stall}, 32'd0);
        memAck = 1'b1; memRdata = 32'h7777_7777;
        @(posedge clk); #1;
        memAck = 1'b0;
        check("rstw_late_ack_wb", {31'd0, wbValid}, 32'd0);
        check("rstw_late_ack_req", {31'd0, memReq}, 32'd0);
        @(posedge clk); #1;
        check("rstw_no_wb", {31'd0, wbValid}, 32'd0);

        // Back-to-back: sw then REGWRITE held during WAIT
        exp_req.push_back('{addr: 32'h0000_0600, we: 1'b1, wdata: 32'h1122_3344, strb: 4'b1111});
        exp_wb.push_back('{rd: 5'd12, data: 32'h0BAD_F00D});
        issue(STORE, F3_W, 32'h0000_0600, 32'h1122_3344, 5'd2);
        inValid = 1'b1; inOp = REGWRITE; inFunc3 = 3'd0; inAddr = 32'h0BAD_F00D; inRd = 5'd12;
        mem_cycle(1, 32'h0, n);
        check("b2b_stall_cycles", n, 2);
        check("b2b_stall_low", {31'd0, stall}, 32'd0);
        check("b2b_wb_not_yet", {31'd0, wbValid}, 32'd0);
        @(posedge clk); #1;
        inValid = 1'b0;
        check("b2b_wb_valid", {31'd0, wbValid}, 32'd1);
        check("b2b_wb_rd", {27'd0, wbRd}, 32'd12);

        repeat (3) begin @(posedge clk); #1; end
        check("end_wb_queue", exp_wb.size(), 32'd0);
        check("end_req_queue", exp_req.size(), 32'd0);
        check("end_err_count", exp_err, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
